b2s_tx_arbiter: RTL and testbench
=================================

// Module: b2s_tx_arbiter
// PURPOSE
//  Round-robin scheduler sharing one b2s single-wire transmitter among NREQ requesters.
//  Latches the granted requester's word, launches one transmitter frame and waits for frame end.
//  Guards each frame with a timeout watchdog, then enforces an idle gap on the line before the next grant.
//  Sits between firmware/config sources and the b2s transmitter datapath.
// PARAMETERS
//  NREQ        4      number of requesters
//  WIDTH       32     payload bits per frame, matching the transmitter's WIDTH
//  IDW         2      width of cur_id, >= clog2(NREQ)
//  CNT_W       16     watchdog/gap counter width; must hold max(GAP_CYC, TIMEOUT_CYC)
//  GAP_CYC     1000   idle clocks enforced between frames
//  TIMEOUT_CYC 65535  clocks allowed from tx_start to tx_done
// PORTS
//  clk       in   1           clock; must be the transmitter's clock
//  rst       in   1           synchronous, active-high reset
//  req       in   NREQ        level request; requester i holds req[i] high until ack[i]
//  req_data  in   NREQ*WIDTH  packed words; requester i occupies [i*WIDTH +: WIDTH]
//  ack       out  NREQ        1-cycle pulse: requester's frame finished (ok or timeout)
//  err       out  NREQ        1-cycle pulse coincident with ack: frame timed out
//  tx_start  out  1           1-cycle pulse that launches one transmitter frame
//  tx_din    out  WIDTH       frame word; stable from tx_start until the frame closes
//  tx_done   in   1           1-cycle pulse from the transmitter at end of frame
//  busy      out  1           high in every state except IDLE
//  cur_id    out  IDW         index of the granted requester; valid while busy
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: ack=0, err=0, tx_start=0, tx_din=0, busy=0, cur_id=0, cnt=0, state=IDLE, last=NREQ-1.
//  - FSM states: IDLE -> ARB -> START -> WAIT -> GAP -> IDLE.
//  - IDLE: busy=0. Any req bit set -> ARB.
//  - ARB:
//    - Search req from (last+1) mod NREQ upward, wrapping; take the first set bit g.
//    - Load tx_din <= req_data[g], cur_id <= g, last <= g; go to START.
//    - No req bit set (request withdrawn) -> IDLE; no tx_start is issued.
//  - START:
//    - tx_start=1 for exactly this cycle; cnt <= 0; go to WAIT.
//    - Latency: req rises in IDLE at cycle t -> tx_start high at t+2.
//  - WAIT:
//    - cnt increments each cycle.
//    - tx_done=1 -> ack[cur_id]=1 next cycle, then GAP.
//    - cnt==TIMEOUT_CYC-1 with no tx_done -> ack[cur_id]=1 and err[cur_id]=1 next cycle, then GAP.
//    - tx_done and timeout in the same cycle -> done wins; err stays 0.
//  - GAP:
//    - cnt is cleared on entry; stay exactly GAP_CYC cycles, then IDLE.
//    - busy=1; tx_din is held.
//  - tx_done outside WAIT is ignored.
//  - At most one bit of ack/err is set at a time; ack/err for requester g are never set unless g was granted.
//  - The requester drops req the cycle after ack. If req is still high, it re-enters arbitration at lowest priority (fair).
//  - req_data is sampled only in ARB; later changes do not affect the frame in flight.
//  - Reset mid-frame:
//    - The FSM returns to IDLE the next cycle with all outputs at reset values; no ack is issued.
//    - The transmitter must be reset on the same rst.
//  - The priority pointer wraps NREQ-1 -> 0. After reset, requester 0 wins the first tie.
// TESTING
//  1. req[0]=1, data0=0xA5A50001, tx_done 500 cycles after tx_start -> one tx_start at t+2, tx_din=0xA5A50001,
//     cur_id=0, ack=4'b0001 the cycle after tx_done, err=0, busy low GAP_CYC cycles later.
//  2. req=4'b1111 held, each requester drops req after its ack -> grant order 0,1,2,3;
//     consecutive tx_start pulses separated by >= GAP_CYC+3 cycles.
//  3. TIMEOUT_CYC=100, req[2]=1, no tx_done -> ack=4'b0100 and err=4'b0100 together, 101 cycles after tx_start.
//  4. TIMEOUT_CYC=100, tx_done on exactly the 100th WAIT cycle -> ack=4'b0100, err=0.
//  5. rst asserted 50 cycles into WAIT (cur_id=3) -> next cycle all outputs 0, no ack; a new req=4'b1001 grants 0 first.
//  6. tx_done pulsed in IDLE and GAP -> no ack. req[1] pulsed for 1 cycle only in IDLE ->
//     ARB finds nothing, no tx_start, back to IDLE.

Source files
------------

// File: rtl/b2s_tx_arbiter.sv
// Round-robin scheduler that shares one b2s single-wire transmitter among NREQ requesters,
// guarding each frame with a timeout watchdog and enforcing an idle gap between frames.
module b2s_tx_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned IDW         = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned GAP_CYC     = 1000,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         err,
  output logic                    tx_start,
  output logic [WIDTH-1:0]        tx_din,
  input  logic                    tx_done,
  output logic                    busy,
  output logic [IDW-1:0]          cur_id
);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [IDW-1:0]   LAST_RST = IDW'(NREQ - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic              tx_start_q, tx_start_d;
  logic [WIDTH-1:0]  tx_din_q, tx_din_d;
  logic              busy_q, busy_d;
  logic [IDW-1:0]    cur_id_q, cur_id_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              gnt_found;
  logic [IDW-1:0]    gnt_id;

  // Rotating search starting just after the last granted requester.
  always_comb begin : arb_c
    int unsigned idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(last_q) + 32'd1 + i) % NREQ;
      if (!gnt_found && req[IDW'(idx)]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = ARB;
      ARB:     state_d = gnt_found ? START : IDLE;
      START:   state_d = WAIT;
      WAIT:    if (tx_done || (cnt_q == TO_LAST)) state_d = GAP;
      GAP:     if (cnt_q == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead so they appear registered in the matching state.
  always_comb begin
    ack_d      = '0;
    err_d      = '0;
    tx_start_d = 1'b0;
    tx_din_d   = tx_din_q;
    cur_id_d   = cur_id_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    busy_d     = (state_d != IDLE);
    unique case (state_q)
      ARB: begin
        if (gnt_found) begin
          tx_din_d   = req_data[32'(gnt_id) * WIDTH +: WIDTH];
          cur_id_d   = gnt_id;
          last_d     = gnt_id;
          tx_start_d = 1'b1;
        end
      end
      START: cnt_d = '0;
      WAIT: begin
        if (tx_done) begin
          ack_d[cur_id_q] = 1'b1;
          cnt_d           = '0;
        end else if (cnt_q == TO_LAST) begin
          ack_d[cur_id_q] = 1'b1;
          err_d[cur_id_q] = 1'b1;
          cnt_d           = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) cnt_d = '0;
        else                   cnt_d = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q      <= '0;
      err_q      <= '0;
      tx_start_q <= 1'b0;
      tx_din_q   <= '0;
      busy_q     <= 1'b0;
      cur_id_q   <= '0;
      last_q     <= LAST_RST;
      cnt_q      <= '0;
    end else begin
      ack_q      <= ack_d;
      err_q      <= err_d;
      tx_start_q <= tx_start_d;
      tx_din_q   <= tx_din_d;
      busy_q     <= busy_d;
      cur_id_q   <= cur_id_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign tx_start = tx_start_q;
  assign tx_din   = tx_din_q;
  assign busy     = busy_q;
  assign cur_id   = cur_id_q;

endmodule

// File: tb/tb_b2s_tx_arbiter.sv
// Directed bench for b2s_tx_arbiter: grant latency, round-robin order, timeout, reset mid-frame,
// and stray tx_done / withdrawn request handling. Short GAP/TIMEOUT keep the run small.
module tb_b2s_tx_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDW   = 2;
  localparam int unsigned GAP   = 16;
  localparam int unsigned TO    = 100;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       err;
  logic                  tx_start;
  logic [WIDTH-1:0]      tx_din;
  logic                  tx_done;
  logic                  busy;
  logic [IDW-1:0]        cur_id;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int s_prev = 0;

  b2s_tx_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .CNT_W(16),
    .GAP_CYC(GAP), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack), .err(err), .tx_start(tx_start), .tx_din(tx_din),
    .tx_done(tx_done), .busy(busy), .cur_id(cur_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    cyc += n;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      tick(1);
      if (tx_start === 1'b1) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  function automatic logic [WIDTH-1:0] word(input int k);
    return req_data[k*WIDTH +: WIDTH];
  endfunction

  initial begin
    rst      = 1'b1;
    req      = '0;
    tx_done  = 1'b0;
    req_data = {32'h33333333, 32'h22222222, 32'h11111111, 32'hA5A50001};
    tick(3);
    chk("rst_ack",      64'(ack),      64'd0);
    chk("rst_err",      64'(err),      64'd0);
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_tx_din",   64'(tx_din),   64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_cur_id",   64'(cur_id),   64'd0);
    rst = 1'b0;
    tick(1);

    // single requester, done 50 cycles after tx_start
    req = 4'b0001;
    tick(1);
    chk("t1_arb_busy",  64'(busy),     64'd1);
    chk("t1_arb_nostart", 64'(tx_start), 64'd0);
    tick(1);
    chk("t1_start",     64'(tx_start), 64'd1);
    chk("t1_din",       64'(tx_din),   64'hA5A50001);
    chk("t1_id",        64'(cur_id),   64'd0);
    req_data[31:0] = 32'hDEADBEEF;
    tick(1);
    chk("t1_start_pulse", 64'(tx_start), 64'd0);
    tick(49);
    chk("t1_no_early_ack", 64'(ack), 64'd0);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    chk("t1_ack",       64'(ack),      64'b0001);
    chk("t1_err",       64'(err),      64'd0);
    chk("t1_din_hold",  64'(tx_din),   64'hA5A50001);
    req = '0;
    req_data[31:0] = 32'hA5A50001;
    tick(1);
    chk("t1_ack_pulse", 64'(ack),      64'd0);
    tick(14);
    chk("t1_gap_busy",  64'(busy),     64'd1);
    tick(1);
    chk("t1_idle",      64'(busy),     64'd0);

    // all four requesting from reset: order 0,1,2,3 with fixed spacing
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_start("t2_start_seen");
      chk("t2_grant", 64'(cur_id), 64'(k));
      chk("t2_din",   64'(tx_din), 64'(word(k)));
      if (k > 0) chk("t2_spacing", 64'(cyc - s_prev), 64'd24);
      s_prev = cyc;
      tick(5);
      tx_done = 1'b1;
      tick(1);
      tx_done = 1'b0;
      chk("t2_ack", 64'(ack), 64'(4'b0001 << k));
      req[k] = 1'b0;
    end
    tick(GAP + 1);
    chk("t2_idle", 64'(busy), 64'd0);

    // timeout: ack+err 101 cycles after tx_start
    req = 4'b0100;
    wait_start("t3_start_seen");
    chk("t3_id", 64'(cur_id), 64'd2);
    tick(100);
    chk("t3_no_ack_yet", 64'(ack), 64'd0);
    tick(1);
    chk("t3_ack", 64'(ack), 64'b0100);
    chk("t3_err", 64'(err), 64'b0100);
    req = '0;
    tick(GAP + 1);
    chk("t3_idle", 64'(busy), 64'd0);

    // done on the 100th WAIT cycle beats the timeout
    req = 4'b0100;
    wait_start("t4_start_seen");
    tick(100);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    chk("t4_ack", 64'(ack), 64'b0100);
    chk("t4_err", 64'(err), 64'd0);
    req = '0;
    tick(GAP + 1);
    chk("t4_idle", 64'(busy), 64'd0);

    // reset 50 cycles into WAIT, then a fresh 1001 request grants 0 first
    req = 4'b1000;
    wait_start("t5_start_seen");
    chk("t5_id", 64'(cur_id), 64'd3);
    tick(50);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_ack",  64'(ack),    64'd0);
    chk("t5_rst_busy", 64'(busy),   64'd0);
    chk("t5_rst_id",   64'(cur_id), 64'd0);
    chk("t5_rst_din",  64'(tx_din), 64'd0);
    rst = 1'b0;
    req = 4'b1001;
    tick(2);
    chk("t5_start", 64'(tx_start), 64'd1);
    chk("t5_id0",   64'(cur_id),   64'd0);
    tick(3);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    chk("t5_ack0", 64'(ack), 64'b0001);
    req = 4'b1000;
    wait_start("t5_start3_seen");
    chk("t5_id3", 64'(cur_id), 64'd3);
    tick(3);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    chk("t5_ack3", 64'(ack), 64'b1000);
    req = '0;

    // stray tx_done in GAP and IDLE, withdrawn request
    tick(2);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    tick(1);
    chk("t6_gap_done_ack", 64'(ack), 64'd0);
    tick(GAP);
    chk("t6_idle", 64'(busy), 64'd0);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    tick(1);
    chk("t6_idle_done_ack",  64'(ack),  64'd0);
    chk("t6_idle_done_busy", 64'(busy), 64'd0);
    req = 4'b0010;
    tick(1);
    req = '0;
    chk("t6_arb_busy", 64'(busy), 64'd1);
    tick(1);
    chk("t6_withdraw_start", 64'(tx_start), 64'd0);
    chk("t6_withdraw_busy",  64'(busy),     64'd0);
    tick(1);
    chk("t6_withdraw_start2", 64'(tx_start), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
